// File: rtl/handshake_fifo_if.sv
// Valid/ready/data channel. The producer side uses the master modport and the
// consumer side uses the slave modport.
interface handshake_fifo_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/handshake_fifo.sv
// Elastic valid/ready buffer with configurable depth and width. The output is
// either registered or, when the buffer is empty, bypassed straight from the input.
module handshake_fifo #(
  parameter int DATA_WIDTH   = 64,
  parameter int DEPTH        = 4,
  parameter int FALL_THROUGH = 0,
  parameter int AFULL_THRESH = DEPTH - 1
) (
  input  logic                         aclk,
  input  logic                         reset,
  input  logic                         flush,
  handshake_fifo_if.slave              s,
  handshake_fifo_if.master             m,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_d;
  logic                  af_q;
  logic                  clr;
  logic                  empty;
  logic                  full;
  logic                  bypass;
  logic                  push;
  logic                  pop;
  logic                  wr_en;
  logic                  rd_en;

  always_comb begin
    clr    = reset | flush;
    empty  = (cnt_q == '0);
    full   = (cnt_q == CW'(DEPTH));
    bypass = (FALL_THROUGH != 0) && empty;

    // Both sides are blocked while clearing, so no handshake completes.
    s.ready = !clr && !full;
    m.valid = !clr && (bypass ? s.valid : !empty);
    m.data  = bypass ? s.data : mem[rd_ptr];

    push  = s.valid & s.ready;
    pop   = m.valid & m.ready;
    // A word consumed in bypass never touches storage.
    wr_en = push && !(bypass && m.ready);
    rd_en = pop && !bypass;

    cnt_d = cnt_q;
    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      af_q   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      cnt_q <= cnt_d;
      af_q  <= (cnt_d >= CW'(AFULL_THRESH));
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_ptr] <= s.data;
  end

  assign count       = cnt_q;
  assign almost_full = af_q;

endmodule

// File: tb/tb_handshake_fifo.sv
// Bench for handshake_fifo: directed vector table on DEPTH=4 registered and
// fall-through instances, then random traffic on DEPTH=8 instances against a queue model.
module tb_handshake_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        fl1, sv1, mr1;
  logic [63:0] d1;
  logic        fl2, sv2, mr2;
  logic [15:0] d2;

  handshake_fifo_if #(.DATA_WIDTH(64)) a_s (), a_m (), b_s (), b_m ();
  handshake_fifo_if #(.DATA_WIDTH(16)) c_s (), c_m (), e_s (), e_m ();

  logic [2:0] a_cnt, b_cnt;
  logic [3:0] c_cnt, e_cnt;
  logic       a_af, b_af, c_af, e_af;

  assign a_s.valid = sv1; assign a_s.data = d1; assign a_m.ready = mr1;
  assign b_s.valid = sv1; assign b_s.data = d1; assign b_m.ready = mr1;
  assign c_s.valid = sv2; assign c_s.data = d2; assign c_m.ready = mr2;
  assign e_s.valid = sv2; assign e_s.data = d2; assign e_m.ready = mr2;

  handshake_fifo #(.DATA_WIDTH(64), .DEPTH(4), .FALL_THROUGH(0)) dut_a (
    .aclk(clk), .reset(rst), .flush(fl1), .s(a_s), .m(a_m),
    .count(a_cnt), .almost_full(a_af));
  handshake_fifo #(.DATA_WIDTH(64), .DEPTH(4), .FALL_THROUGH(1)) dut_b (
    .aclk(clk), .reset(rst), .flush(fl1), .s(b_s), .m(b_m),
    .count(b_cnt), .almost_full(b_af));
  handshake_fifo #(.DATA_WIDTH(16), .DEPTH(8), .FALL_THROUGH(0)) dut_c (
    .aclk(clk), .reset(rst), .flush(fl2), .s(c_s), .m(c_m),
    .count(c_cnt), .almost_full(c_af));
  handshake_fifo #(.DATA_WIDTH(16), .DEPTH(8), .FALL_THROUGH(1)) dut_e (
    .aclk(clk), .reset(rst), .flush(fl2), .s(e_s), .m(e_m),
    .count(e_cnt), .almost_full(e_af));

  int nerr = 0;
  int nchk = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          sel;
    bit          rst;
    bit          fl;
    bit          sv;
    logic [63:0] d;
    bit          mr;
    bit          e_sr;
    bit          e_mv;
    logic [63:0] e_md;
    int          e_cnt;
    bit          e_af;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit sel, input bit r, input bit f, input bit v, input logic [63:0] d,
                     input bit mr, input bit esr, input bit emv, input logic [63:0] emd,
                     input int ecnt, input bit eaf);
    vec_t t;
    t.sel = sel; t.rst = r; t.fl = f; t.sv = v; t.d = d; t.mr = mr;
    t.e_sr = esr; t.e_mv = emv; t.e_md = emd; t.e_cnt = ecnt; t.e_af = eaf;
    vecs.push_back(t);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] q [2][$];
  bit          stall [2];
  logic [15:0] held [2];

  initial begin
    logic        o_sr, o_mv, o_af;
    logic [63:0] o_md;
    int          o_cnt;
    int          popped;

    rst = 1'b1; fl1 = 1'b0; sv1 = 1'b0; mr1 = 1'b0; d1 = '0;
    fl2 = 1'b0; sv2 = 1'b0; mr2 = 1'b0; d2 = '0;
    repeat (2) @(posedge clk);

    // sel rst fl sv data mr | s_ready m_valid m_data count afull
    // DEPTH=4 registered: fill, overfill, drain with simultaneous push/pop
    add(0,0,0,1,64'h11,0, 1,0,0,   0,0);
    add(0,0,0,1,64'h22,0, 1,1,64'h11,1,0);
    add(0,0,0,1,64'h33,0, 1,1,64'h11,2,0);
    add(0,0,0,1,64'h44,0, 1,1,64'h11,3,1);
    add(0,0,0,1,64'h55,0, 0,1,64'h11,4,1);
    add(0,0,0,1,64'h55,1, 0,1,64'h11,4,1);
    add(0,0,0,1,64'h55,1, 1,1,64'h22,3,1);
    add(0,0,0,0,64'h0, 1, 1,1,64'h33,3,1);
    add(0,0,0,0,64'h0, 1, 1,1,64'h44,2,0);
    add(0,0,0,0,64'h0, 1, 1,1,64'h55,1,0);
    add(0,0,0,0,64'h0, 1, 1,0,0,   0,0);
    // one-cycle latency through the registered path
    add(0,0,0,1,64'hAA,1, 1,0,0,   0,0);
    add(0,0,0,0,64'h0, 1, 1,1,64'hAA,1,0);
    add(0,0,0,0,64'h0, 0, 1,0,0,   0,0);
    // push and pop together at count=1
    add(0,0,0,1,64'h01,0, 1,0,0,   0,0);
    add(0,0,0,1,64'h02,1, 1,1,64'h01,1,0);
    add(0,0,0,0,64'h0, 0, 1,1,64'h02,1,0);
    add(0,0,0,0,64'h0, 1, 1,1,64'h02,1,0);
    add(0,0,0,0,64'h0, 0, 1,0,0,   0,0);
    // flush with three entries
    add(0,0,0,1,64'h61,0, 1,0,0,   0,0);
    add(0,0,0,1,64'h62,0, 1,1,64'h61,1,0);
    add(0,0,0,1,64'h63,0, 1,1,64'h61,2,0);
    add(0,0,1,1,64'h64,1, 0,0,0,   3,1);
    add(0,0,0,0,64'h0, 1, 1,0,0,   0,0);
    // reset with three entries, then old data must not reappear
    add(0,0,0,1,64'h71,0, 1,0,0,   0,0);
    add(0,0,0,1,64'h72,0, 1,1,64'h71,1,0);
    add(0,0,0,1,64'h73,0, 1,1,64'h71,2,0);
    add(0,1,0,1,64'h74,1, 0,0,0,   3,1);
    add(0,0,0,0,64'h0, 1, 1,0,0,   0,0);
    add(0,0,0,1,64'h81,0, 1,0,0,   0,0);
    add(0,0,0,0,64'h0, 0, 1,1,64'h81,1,0);
    add(0,0,0,0,64'h0, 1, 1,1,64'h81,1,0);
    add(0,0,0,0,64'h0, 0, 1,0,0,   0,0);
    // flush and reset together
    add(0,0,0,1,64'h91,0, 1,0,0,   0,0);
    add(0,1,1,0,64'h0, 0, 0,0,0,   1,0);
    add(0,0,0,0,64'h0, 0, 1,0,0,   0,0);
    // DEPTH=4 fall-through instance, cleanly reset first
    add(0,1,0,0,64'h0, 0, 0,0,0,   0,0);
    add(1,0,0,1,64'h5A,1, 1,1,64'h5A,0,0);
    add(1,0,0,0,64'h0, 0, 1,0,0,   0,0);
    add(1,0,0,1,64'h5A,0, 1,1,64'h5A,0,0);
    add(1,0,0,0,64'h0, 0, 1,1,64'h5A,1,0);
    add(1,0,0,1,64'h5B,0, 1,1,64'h5A,1,0);
    add(1,0,0,0,64'h0, 1, 1,1,64'h5A,2,0);
    add(1,0,0,0,64'h0, 1, 1,1,64'h5B,1,0);
    add(1,0,0,1,64'h5C,1, 1,1,64'h5C,0,0);
    add(1,0,0,0,64'h0, 0, 1,0,0,   0,0);
    add(1,0,1,1,64'h5D,1, 0,0,0,   0,0);
    add(1,0,0,0,64'h0, 0, 1,0,0,   0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; fl1 = vecs[i].fl; sv1 = vecs[i].sv; d1 = vecs[i].d; mr1 = vecs[i].mr;
      #1;
      if (vecs[i].sel) begin
        o_sr = b_s.ready; o_mv = b_m.valid; o_md = b_m.data; o_cnt = int'(b_cnt); o_af = b_af;
      end else begin
        o_sr = a_s.ready; o_mv = a_m.valid; o_md = a_m.data; o_cnt = int'(a_cnt); o_af = a_af;
      end
      chk($sformatf("row%0d s_ready", i), 64'(o_sr), 64'(vecs[i].e_sr));
      chk($sformatf("row%0d m_valid", i), 64'(o_mv), 64'(vecs[i].e_mv));
      if (vecs[i].e_mv) chk($sformatf("row%0d m_data", i), o_md, vecs[i].e_md);
      chk($sformatf("row%0d count", i), 64'(o_cnt), 64'(vecs[i].e_cnt));
      chk($sformatf("row%0d almost_full", i), 64'(o_af), 64'(vecs[i].e_af));
    end

    @(negedge clk);
    sv1 = 1'b0; mr1 = 1'b0; fl1 = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      q[k].delete();
      stall[k] = 1'b0;
    end
    popped = 0;

    // Random traffic on DEPTH=8: index 0 is registered, index 1 is fall-through.
    for (int cyc = 0; cyc < 60000 && popped < 10000; cyc++) begin
      if (cyc != 0) @(negedge clk);
      sv2 = 1'($urandom % 2);
      mr2 = 1'($urandom % 2);
      d2  = 16'($urandom);
      fl2 = ($urandom % 200) == 0;
      #1;
      for (int k = 0; k < 2; k++) begin
        int          n;
        bit          byp, esr, emv, push, pop;
        logic [15:0] emd;
        logic        r_sr, r_mv, r_af;
        logic [15:0] r_md;
        int          r_cnt;
        if (k == 0) begin
          r_sr = c_s.ready; r_mv = c_m.valid; r_md = c_m.data; r_cnt = int'(c_cnt); r_af = c_af;
        end else begin
          r_sr = e_s.ready; r_mv = e_m.valid; r_md = e_m.data; r_cnt = int'(e_cnt); r_af = e_af;
        end
        n   = q[k].size();
        byp = (k == 1) && (n == 0);
        esr = !fl2 && (n != 8);
        emv = !fl2 && (byp ? sv2 : (n != 0));
        emd = byp ? d2 : (n != 0 ? q[k][0] : 16'h0);
        chk($sformatf("rand%0d c%0d s_ready", k, cyc), 64'(r_sr), 64'(esr));
        chk($sformatf("rand%0d c%0d m_valid", k, cyc), 64'(r_mv), 64'(emv));
        if (emv) chk($sformatf("rand%0d c%0d m_data", k, cyc), 64'(r_md), 64'(emd));
        chk($sformatf("rand%0d c%0d count", k, cyc), 64'(r_cnt), 64'(n));
        chk($sformatf("rand%0d c%0d almost_full", k, cyc), 64'(r_af), 64'(n >= 7));
        if (stall[k] && !fl2) begin
          chk($sformatf("rand%0d c%0d stall valid", k, cyc), 64'(r_mv), 64'(1));
          chk($sformatf("rand%0d c%0d stall data", k, cyc), 64'(r_md), 64'(held[k]));
        end
        push = sv2 && esr;
        pop  = emv && mr2;
        if (fl2) begin
          q[k].delete();
        end else begin
          if (push) q[k].push_back(d2);
          if (pop) void'(q[k].pop_front());
        end
        stall[k] = emv && !mr2;
        held[k]  = r_md;
        if (k == 0 && pop) popped++;
      end
    end
    chk("random words popped", 64'(popped >= 10000), 64'(1));

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/handshake_fifo.md
Name: handshake_fifo

Overview:
- Parametrised elastic buffer between a valid/ready/data slave channel and a master channel; the buffered successor to the bare handshake bundle.
- Adds configurable depth and width, registered or fall-through output mode, occupancy count, almost-full flag and synchronous flush.
- Placed between load-balancer stages to absorb backpressure and break ready paths.

Parameters:
DATA_WIDTH, 64, payload width in bits (>=1)
DEPTH, 4, entry count; power of two, >=2
FALL_THROUGH, 0, 0 = registered output; 1 = empty-bypass output
AFULL_THRESH, DEPTH-1, almost_full asserts when count >= AFULL_THRESH (1..DEPTH)

Ports:
aclk  in  1  clock; all logic on rising edge
reset  in  1  synchronous active-high reset
flush  in  1  synchronous clear of contents, active-high
s_valid  in  1  upstream data valid
s_ready  out  1  buffer can accept
s_data  in  DATA_WIDTH  upstream payload
m_valid  out  1  output data valid
m_ready  in  1  downstream accept
m_data  out  DATA_WIDTH  output payload
count  out  $clog2(DEPTH+1)  current occupancy
almost_full  out  1  count >= AFULL_THRESH

Behaviour:
- Reset (sampled at aclk edge): pointers = 0, count = 0, m_valid = 0, s_ready = 1 from the first cycle after reset, almost_full = 0, m_data don't-care. Reset mid-transfer discards all entries; no handshake completes in the reset cycle.
- Push = s_valid & s_ready; pop = m_valid & m_ready. Both are evaluated at the same edge.
- s_ready = !full (count != DEPTH). It is never combinationally dependent on m_ready. When full, a simultaneous pop does not enable a push in that cycle.
- count: push only +1, pop only -1, push & pop unchanged. Read/write pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- FALL_THROUGH=0:
  - m_valid = count != 0; m_data = entry at read pointer, sourced from a register.
  - Latency: a push at edge t makes the word visible at m_* after t; it can be popped at edge t+1 at the earliest.
  - Push & pop when count = 1: the output advances to the new word and count stays 1.
- FALL_THROUGH=1:
  - When count = 0: m_valid = s_valid and m_data = s_data (combinational).
  - If m_ready is also high, the word is transferred with zero latency. There is no storage write and count stays 0.
  - If empty, s_valid = 1 and m_ready = 0: the word is stored and count becomes 1.
  - When count != 0, behaviour is identical to mode 0. Ordering is always preserved.
- Payload must be held stable by upstream while s_valid & !s_ready (AXI-style). The block must hold m_valid and m_data stable while m_valid & !m_ready.
- flush:
  - Same effect as reset on pointers, count, m_valid and almost_full.
  - During a flush cycle s_ready = 0 and m_valid = 0, so no handshake completes.
  - If flush and reset are both high, reset wins (identical result).
- almost_full is registered-consistent with count: it updates in the same cycle as count.
- Storage needs no reset. Entries beyond count are never presented.

Test Plan:
- DEPTH=4, mode 0: reset, push 0x11,0x22,0x33,0x44 with m_ready=0 -> count 1,2,3,4; s_ready=0 after the 4th push; almost_full=1 once count=3; a 5th s_valid is not accepted.
- From full, m_ready=1 and s_valid=1 held for 1 cycle -> pop 0x11, no push that cycle, count=3; next cycle push and pop together -> count stays 3; output order 0x11,0x22,0x33,0x44,new.
- Mode 0, empty, push 0xAA at edge t with m_ready=1 -> m_valid first high after t; pop at t+1; count back to 0.
- FALL_THROUGH=1, empty, s_valid=1, s_data=0x5A, m_ready=1 -> m_valid=1, m_data=0x5A the same cycle; count stays 0. Repeat with m_ready=0 -> count=1 and 0x5A is held on m_data.
- Random valid/ready (50% each), 10k words, DEPTH=8 -> output sequence equals input sequence; count equals pushes minus pops at every cycle; m_data stable while stalled.
- Fill to 3 entries then assert flush (also repeat with reset) -> next cycle count=0, m_valid=0, s_ready=1; the old 3 entries are never output.
